// File: rtl/ysyx_23060124_wbu.sv
// Write-back unit: registers GPR/CSR writes, redirects, ecall trap sequencing and ebreak halt.
// Optional retire counter enabled by YSYX_23060124_WBU_RETIRE_CNT_EN.
module ysyx_23060124_wbu (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc_next,
    input  logic [31:0] i_res,
    input  logic [3:0]  i_rd_addr,
    input  logic [11:0] i_csr_addr,
    input  logic        i_wen,
    input  logic        i_csr_wen,
    input  logic        i_brch,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic        i_mret,
    input  logic        i_ecall,
    input  logic        i_ebreak,
    output logic        o_rf_wen,
    output logic [3:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_csr_wen,
    output logic [11:0] o_csr_waddr,
    output logic [31:0] o_csr_wdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_halt,
    output logic        o_retire,
    output logic [63:0] o_retire_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        TRAP2,
        HALT
    } state_t;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    state_t      state;
    logic [31:0] trap_pc;
    logic        accept;
    logic        jump;

    assign accept = i_valid & o_ready;
    assign jump   = i_brch | i_jal | i_jalr | i_mret;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            trap_pc       <= '0;
            o_ready       <= 1'b0;
            o_rf_wen      <= 1'b0;
            o_rf_waddr    <= '0;
            o_rf_wdata    <= '0;
            o_csr_wen     <= 1'b0;
            o_csr_waddr   <= '0;
            o_csr_wdata   <= '0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_halt        <= 1'b0;
            o_retire      <= 1'b0;
        end else begin
            // every effect is a one-cycle pulse unless re-asserted below
            o_rf_wen      <= 1'b0;
            o_rf_waddr    <= '0;
            o_rf_wdata    <= '0;
            o_csr_wen     <= 1'b0;
            o_csr_waddr   <= '0;
            o_csr_wdata   <= '0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_halt        <= 1'b0;
            o_retire      <= 1'b0;
            case (state)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (accept) begin
                        if (i_ebreak) begin
                            o_retire <= 1'b1;
                            o_halt   <= 1'b1;
                            o_ready  <= 1'b0;
                            state    <= HALT;
                        end else if (i_ecall) begin
                            o_csr_wen   <= 1'b1;
                            o_csr_waddr <= CSR_MEPC;
                            o_csr_wdata <= i_res;
                            trap_pc     <= i_pc_next;
                            o_ready     <= 1'b0;
                            state       <= TRAP2;
                        end else begin
                            if (i_wen && i_rd_addr != 4'd0) begin
                                o_rf_wen   <= 1'b1;
                                o_rf_waddr <= i_rd_addr;
                                o_rf_wdata <= i_res;
                            end
                            if (i_csr_wen) begin
                                o_csr_wen   <= 1'b1;
                                o_csr_waddr <= i_csr_addr;
                                o_csr_wdata <= i_res;
                            end
                            if (jump) begin
                                o_redirect    <= 1'b1;
                                o_redirect_pc <= i_pc_next;
                            end
                            o_retire <= 1'b1;
                        end
                    end
                end
                TRAP2: begin
                    o_csr_wen     <= 1'b1;
                    o_csr_waddr   <= CSR_MCAUSE;
                    o_csr_wdata   <= 32'd11;
                    o_redirect    <= 1'b1;
                    o_redirect_pc <= trap_pc;
                    o_retire      <= 1'b1;
                    o_ready       <= 1'b1;
                    state         <= IDLE;
                end
                HALT: begin
                    o_halt  <= 1'b1;
                    o_ready <= 1'b0;
                end
                default: begin
                    o_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef YSYX_23060124_WBU_RETIRE_CNT_EN
    logic [63:0] retire_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (o_retire) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end

    assign o_retire_cnt = retire_cnt;
`else
    assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Scoreboard bench for ysyx_23060124_wbu: random instruction stream against a rule-level model.
// Counter wrap is exercised when YSYX_23060124_WBU_RETIRE_CNT_EN is defined.
module tb_ysyx_23060124_wbu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc_next;
    logic [31:0] i_res;
    logic [3:0]  i_rd_addr;
    logic [11:0] i_csr_addr;
    logic        i_wen, i_csr_wen;
    logic        i_brch, i_jal, i_jalr, i_mret, i_ecall, i_ebreak;
    logic        o_rf_wen;
    logic [3:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_halt, o_retire;
    logic [63:0] o_retire_cnt;

    ysyx_23060124_wbu dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc_next(i_pc_next), .i_res(i_res), .i_rd_addr(i_rd_addr),
        .i_csr_addr(i_csr_addr), .i_wen(i_wen), .i_csr_wen(i_csr_wen),
        .i_brch(i_brch), .i_jal(i_jal), .i_jalr(i_jalr), .i_mret(i_mret),
        .i_ecall(i_ecall), .i_ebreak(i_ebreak),
        .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_csr_wen(o_csr_wen), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_halt(o_halt), .o_retire(o_retire), .o_retire_cnt(o_retire_cnt)
    );

    always #5 clock = ~clock;

`ifdef YSYX_23060124_WBU_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rf_wen;
        logic [3:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        retire;
        logic        halt;
        logic [63:0] cnt;
    } obs_t;

    typedef struct {
        obs_t o;
        int   due;
    } exp_t;

    typedef struct {
        logic [31:0] pc_next;
        logic [31:0] res;
        logic [3:0]  rd;
        logic [11:0] csr;
        logic        wen, csr_wen, brch, jal, jalr, mret, ecall, ebreak;
    } txn_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] exp_cnt = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    // monitor: compare at the due cycle, flag any pulse nobody asked for
    always @(negedge clock) begin
        obs_t g;
        exp_t e;
        g.rf_wen      = o_rf_wen;
        g.rf_waddr    = o_rf_wen ? o_rf_waddr : '0;
        g.rf_wdata    = o_rf_wen ? o_rf_wdata : '0;
        g.csr_wen     = o_csr_wen;
        g.csr_waddr   = o_csr_wen ? o_csr_waddr : '0;
        g.csr_wdata   = o_csr_wen ? o_csr_wdata : '0;
        g.redirect    = o_redirect;
        g.redirect_pc = o_redirect ? o_redirect_pc : '0;
        g.retire      = o_retire;
        g.halt        = o_halt;
        g.cnt         = o_retire_cnt;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            e.o.cnt = CNT_EN ? exp_cnt : 64'd0;
            n_cmp++;
            if (g !== e.o) begin
                n_fail++;
                $display("FAIL event@%0d: got %h required %h", cyc, g, e.o);
            end
            if (CNT_EN && e.o.retire) exp_cnt = exp_cnt + 64'd1;
        end else if ((o_rf_wen | o_csr_wen | o_redirect | o_retire) === 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious@%0d: got %h required no pulse", cyc, g);
        end
    end

    task automatic push_model(input txn_t t);
        exp_t a;
        exp_t b;
        a.o = '0;
        a.due = cyc + 1;
        b.o = '0;
        b.due = cyc + 2;
        if (t.ebreak) begin
            a.o.retire = 1'b1;
            a.o.halt = 1'b1;
            sb.push_back(a);
        end else if (t.ecall) begin
            a.o.csr_wen = 1'b1;
            a.o.csr_waddr = 12'h341;
            a.o.csr_wdata = t.res;
            sb.push_back(a);
            b.o.csr_wen = 1'b1;
            b.o.csr_waddr = 12'h342;
            b.o.csr_wdata = 32'd11;
            b.o.redirect = 1'b1;
            b.o.redirect_pc = t.pc_next;
            b.o.retire = 1'b1;
            sb.push_back(b);
        end else begin
            if (t.wen && t.rd != 4'd0) begin
                a.o.rf_wen = 1'b1;
                a.o.rf_waddr = t.rd;
                a.o.rf_wdata = t.res;
            end
            if (t.csr_wen) begin
                a.o.csr_wen = 1'b1;
                a.o.csr_waddr = t.csr;
                a.o.csr_wdata = t.res;
            end
            if (t.brch || t.jal || t.jalr || t.mret) begin
                a.o.redirect = 1'b1;
                a.o.redirect_pc = t.pc_next;
            end
            a.o.retire = 1'b1;
            sb.push_back(a);
        end
    endtask

    function automatic txn_t zero_txn();
        txn_t t;
        t.pc_next = '0; t.res = '0; t.rd = '0; t.csr = '0;
        t.wen = 0; t.csr_wen = 0; t.brch = 0; t.jal = 0;
        t.jalr = 0; t.mret = 0; t.ecall = 0; t.ebreak = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t = zero_txn();
        t.pc_next = $urandom;
        t.res = $urandom;
        t.rd = 4'($urandom);
        t.csr = 12'($urandom);
        t.wen = 1'($urandom);
        t.csr_wen = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 9))
            1: t.brch = 1'b1;
            2: t.jal = 1'b1;
            3: t.jalr = 1'b1;
            4: t.mret = 1'b1;
            5: begin
                t.ecall = 1'b1;
                t.jalr = 1'($urandom);
            end
            default: ;
        endcase
        return t;
    endfunction

    task automatic drive(input txn_t t, input logic v);
        i_valid = v;
        i_pc_next = t.pc_next;
        i_res = t.res;
        i_rd_addr = t.rd;
        i_csr_addr = t.csr;
        i_wen = t.wen;
        i_csr_wen = t.csr_wen;
        i_brch = t.brch;
        i_jal = t.jal;
        i_jalr = t.jalr;
        i_mret = t.mret;
        i_ecall = t.ecall;
        i_ebreak = t.ebreak;
    endtask

    // called at a negedge; returns at the negedge where the first effect is visible
    task automatic issue(input txn_t t);
        int k = 0;
        while (o_ready !== 1'b1) begin
            if (k == 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ready_timeout: o_ready %b required 1", o_ready);
                drive(zero_txn(), 1'b0);
                return;
            end
            drive(rand_txn(), 1'b1);
            @(negedge clock);
            k++;
        end
        drive(t, 1'b1);
        push_model(t);
        @(negedge clock);
        i_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        txn_t t;
        drive(zero_txn(), 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_ready", 64'(o_ready), 64'd0);
        chk("reset_flags", 64'({o_rf_wen, o_csr_wen, o_redirect, o_retire, o_halt}), 64'd0);
        chk("reset_rf", 64'({o_rf_waddr, o_rf_wdata}), 64'd0);
        chk("reset_csr", 64'({o_csr_waddr, o_csr_wdata}), 64'd0);
        chk("reset_pc", 64'(o_redirect_pc), 64'd0);
        chk("reset_cnt", o_retire_cnt, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 64'(o_ready), 64'd1);

        t = zero_txn(); t.wen = 1; t.rd = 4'd5; t.res = 32'h1234;
        issue(t);
        t = zero_txn(); t.wen = 1; t.rd = 4'd0; t.res = 32'hdead_beef;
        issue(t);
        t = zero_txn(); t.wen = 1; t.rd = 4'd1; t.jal = 1;
        t.res = 32'h8000_0008; t.pc_next = 32'h8000_0010;
        issue(t);

        t = zero_txn(); t.ecall = 1; t.res = 32'h8000_0100; t.pc_next = 32'h8000_0400;
        issue(t);
        chk("ecall_busy", 64'(o_ready), 64'd0);
        @(negedge clock);
        chk("ecall_ready_back", 64'(o_ready), 64'd1);

        repeat (250) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(rand_txn(), 1'b0);
                @(negedge clock);
            end
            issue(rand_txn());
        end

        // reset while the mcause write is pending
        t = zero_txn(); t.ecall = 1; t.res = 32'h8000_0200; t.pc_next = 32'h8000_0500;
        issue(t);
        void'(sb.pop_back());
        reset = 1'b1;
        exp_cnt = '0;
        @(negedge clock);
        chk("trap2_reset_outs", 64'({o_csr_wen, o_redirect, o_retire, o_rf_wen}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("trap2_reset_ready", 64'(o_ready), 64'd1);

`ifdef YSYX_23060124_WBU_RETIRE_CNT_EN
        force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        release dut.retire_cnt;
        exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        t = zero_txn(); t.wen = 1; t.rd = 4'd7; t.res = 32'h55;
        issue(t);
        @(negedge clock);
        chk("cnt_wrap", o_retire_cnt, 64'd0);
`endif

        t = zero_txn(); t.ebreak = 1; t.ecall = 1; t.wen = 1; t.rd = 4'd3;
        t.csr_wen = 1; t.csr = 12'h300; t.jal = 1; t.res = 32'h77;
        issue(t);
        for (int i = 0; i < 100; i++) begin
            chk("halt_level", 64'(o_halt), 64'd1);
            chk("halt_ready", 64'(o_ready), 64'd0);
            drive(rand_txn(), 1'b1);
            @(negedge clock);
        end
        drive(zero_txn(), 1'b0);
        reset = 1'b1;
        exp_cnt = '0;
        @(negedge clock);
        chk("halt_reset_flags", 64'({o_ready, o_halt, o_retire, o_rf_wen, o_csr_wen, o_redirect}), 64'd0);
        chk("halt_reset_cnt", o_retire_cnt, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("halt_reset_ready", 64'(o_ready), 64'd1);
        chk("halt_reset_halt", 64'(o_halt), 64'd0);

        repeat (3) @(negedge clock);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_wbu.md
YSYX_23060124_WBU -- requirements
Module: ysyx_23060124_wbu

Interface
REQ-001 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port i_valid, input, 1: upstream EXU/WBU register holds a valid instruction.
REQ-004 SHALL have port o_ready, output, 1: block can accept an instruction this cycle.
REQ-005 SHALL have port i_pc_next, input, 32: redirect target (branch/jal/jalr target, mepc for mret, mtvec for ecall).
REQ-006 SHALL have port i_res, input, 32: result; for ecall it carries the ecall's own PC.
REQ-007 SHALL have port i_rd_addr, input, 4: GPR destination.
REQ-008 SHALL have port i_csr_addr, input, 12: CSR destination.
REQ-009 SHALL have ports i_wen and i_csr_wen, input, 1 each: GPR write enable and CSR write enable.
REQ-010 SHALL have ports i_brch, i_jal, i_jalr, i_mret, i_ecall and i_ebreak, input, 1 each: instruction class flags.
REQ-011 SHALL have ports o_rf_wen (1), o_rf_waddr (4) and o_rf_wdata (32), outputs: GPR write port.
REQ-012 SHALL have ports o_csr_wen (1), o_csr_waddr (12) and o_csr_wdata (32), outputs: CSR write port.
REQ-013 SHALL have ports o_redirect (1) and o_redirect_pc (32), outputs: PC redirect pulse and target to IFU.
REQ-014 SHALL have ports o_halt (1) and o_retire (1), outputs: ebreak halt level and one-cycle retire pulse.
REQ-015 SHALL have port o_retire_cnt, output, 64: count of retired instructions.

Function
REQ-016 SHALL implement FSM states IDLE, TRAP2 and HALT; o_ready SHALL be 1 only in IDLE and SHALL NOT depend on i_valid.
REQ-017 SHALL define accept as i_valid & o_ready; with no accept, all write, redirect and retire outputs SHALL be 0 in the following cycle.
REQ-018 SHALL register all outputs; effects of an accept at edge N SHALL be visible for exactly one cycle after edge N (latency 1).
REQ-019 On accept with i_wen=1 and i_rd_addr!=0, SHALL assert o_rf_wen, o_rf_waddr=i_rd_addr and o_rf_wdata=i_res; for i_rd_addr=0, o_rf_wen SHALL stay 0.
REQ-020 On accept with i_csr_wen=1, SHALL assert o_csr_wen, o_csr_waddr=i_csr_addr and o_csr_wdata=i_res, in the same cycle as any GPR write.
REQ-021 On accept with any of i_brch, i_jal, i_jalr or i_mret, SHALL pulse o_redirect with o_redirect_pc=i_pc_next.
REQ-022 On accept of an ecall: cycle 1 SHALL write CSR 0x341 (mepc)=i_res; the FSM SHALL move to TRAP2, latching i_pc_next; cycle 2 SHALL write CSR 0x342 (mcause)=32'd11, pulse o_redirect to the latched target and retire; the FSM SHALL then return to IDLE.
REQ-023 ecall and ebreak SHALL take priority; i_wen, i_csr_wen and the jump flags SHALL be ignored when either is set; ebreak wins over ecall.
REQ-024 On accept of an ebreak, the block SHALL perform no writes, pulse o_retire, enter HALT and set o_halt=1; it SHALL hold HALT (o_ready=0) until reset.
REQ-025 SHALL pulse o_retire once per retired instruction: accept cycle+1 for normal instructions, the TRAP2 cycle for ecall.

Reset
REQ-026 While reset is high, the FSM SHALL enter IDLE and every output SHALL be 0, except o_ready=1 from the first cycle after reset deasserts.
REQ-027 A reset during TRAP2 or HALT SHALL abandon the pending mcause write and redirect, with no partial output on the next cycle.

Configuration
REQ-028 With macro YSYX_23060124_WBU_RETIRE_CNT_EN defined, a 64-bit counter SHALL increment on each o_retire pulse, reset to 0 and wrap from all-ones to 0.
REQ-029 Without YSYX_23060124_WBU_RETIRE_CNT_EN, o_retire_cnt SHALL be tied to 0 and no counter flops SHALL exist; o_retire SHALL be unaffected.

Verification
REQ-030 SHALL test: add with i_wen=1, rd=5, res=0x1234 accepted -> next cycle o_rf_wen=1, waddr=5, wdata=0x1234, o_retire=1, no redirect.
REQ-031 SHALL test: i_wen=1 with rd=0 -> o_rf_wen=0 and o_retire=1; jal with rd=1, pc_next=0x80000010 -> rf write to x1 and redirect pulse to 0x80000010 in the same cycle.
REQ-032 SHALL test: ecall with res=0x80000100, pc_next=0x80000400 -> cycle 1 CSR 0x341=0x80000100, o_ready=0; cycle 2 CSR 0x342=11, redirect to 0x80000400, retire; o_ready=1 after.
REQ-033 SHALL test: ebreak with i_wen=1 -> no rf write, o_halt=1 held and o_ready=0 for 100 cycles despite i_valid=1; reset -> IDLE with all outputs 0.
REQ-034 SHALL test: reset asserted in TRAP2 -> no mcause write and no redirect; with macro, counter preloaded to 0xFFFF_FFFF_FFFF_FFFF plus one retire -> 0.
